// File: rtl/lane_rr_scheduler_pkg.sv
// Shared constants, types and the round-robin pick helper for the lane scheduler.
package lane_rr_scheduler_pkg;

  localparam int         LANES        = 4;
  localparam logic [7:0] IDLE_SYM_DEF = 8'hBC;

  typedef logic [1:0] lane_idx_t;

  typedef struct packed {
    logic      found;
    lane_idx_t idx;
  } pick_t;

  // Scan last+1 .. last+4 (mod 4) and return the first requesting lane.
  // The fourth candidate wraps back to 'last' itself, so a lone requester
  // that was just served can be served again.
  function automatic pick_t rr_pick(input logic [LANES-1:0] req, input lane_idx_t last);
    pick_t     p;
    lane_idx_t cand;
    p.found = 1'b0;
    p.idx   = last;
    for (int k = 1; k <= LANES; k++) begin
      cand = last + lane_idx_t'(k);
      if (!p.found && req[cand]) begin
        p.found = 1'b1;
        p.idx   = cand;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/lane_rr_scheduler_fifo.sv
// Per-lane FIFO. The caller gates push/pop; pointers wrap modulo DEPTH.
module lane_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk4f,
  input  logic                     reset_L,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage array; contents need no reset since count guards every read.
  always_ff @(posedge clk4f) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; push+pop in one cycle leaves count unchanged.
  always_ff @(posedge clk4f) begin
    if (!reset_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/lane_rr_scheduler.sv
// Four-lane round-robin merger: per-lane FIFOs feed a rotating priority
// arbiter that emits one symbol per clk4f cycle when downstream is ready.
module lane_rr_scheduler
  import lane_rr_scheduler_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               DEPTH    = 2,
  parameter logic [WIDTH-1:0] IDLE_SYM = IDLE_SYM_DEF
) (
  input  logic             clk4f,
  input  logic             reset_L,
  input  logic [WIDTH:0]   data0,
  input  logic [WIDTH:0]   data1,
  input  logic [WIDTH:0]   data2,
  input  logic [WIDTH:0]   data3,
  input  logic [LANES-1:0] lane_en,
  input  logic             out_ready,
  output logic [WIDTH:0]   data_out,
  output logic [1:0]       grant,
  output logic [LANES-1:0] lane_full,
  output logic [LANES-1:0] err_overflow
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH:0]   lane_in [LANES];
  logic [WIDTH-1:0] head    [LANES];
  logic [CW-1:0]    count   [LANES];
  logic [LANES-1:0] full;
  logic [LANES-1:0] empty;
  logic [LANES-1:0] req;
  logic [LANES-1:0] push_req;
  logic [LANES-1:0] push;
  logic [LANES-1:0] pop;
  logic [LANES-1:0] drop;
  lane_idx_t        rr_last;
  pick_t            pick;

  assign lane_in[0] = data0;
  assign lane_in[1] = data1;
  assign lane_in[2] = data2;
  assign lane_in[3] = data3;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk4f   (clk4f),
      .reset_L (reset_L),
      .push    (push[i]),
      .pop     (pop[i]),
      .din     (lane_in[i][WIDTH-1:0]),
      .dout    (head[i]),
      .count   (count[i]),
      .full    (full[i]),
      .empty   (empty[i])
    );
  end

  // Arbitration on pre-edge FIFO state, then push gating that lets a full
  // lane accept a new symbol when its head is popped in the same cycle.
  always_comb begin
    req  = lane_en & ~empty;
    pick = rr_pick(req, rr_last);
    pop      = '0;
    push_req = '0;
    push     = '0;
    drop     = '0;
    lane_full = '0;
    for (int i = 0; i < LANES; i++) begin
      pop[i]       = out_ready && pick.found && (pick.idx == lane_idx_t'(i));
      push_req[i]  = lane_in[i][WIDTH] && lane_en[i];
      push[i]      = push_req[i] && (!full[i] || pop[i]);
      drop[i]      = push_req[i] && full[i] && !pop[i];
      lane_full[i] = (count[i] == CW'(DEPTH));
    end
  end

  // Output registers, round-robin pointer and sticky overflow flags.
  always_ff @(posedge clk4f) begin
    if (!reset_L) begin
      data_out     <= {1'b0, IDLE_SYM};
      grant        <= '0;
      rr_last      <= 2'd3;
      err_overflow <= '0;
    end else begin
      if (out_ready) begin
        if (pick.found) begin
          data_out <= {1'b1, head[pick.idx]};
          grant    <= pick.idx;
          rr_last  <= pick.idx;
        end else begin
          data_out <= {1'b0, IDLE_SYM};
        end
      end
      err_overflow <= err_overflow | drop;
    end
  end

endmodule

// File: tb/tb_lane_rr_scheduler.sv
// Directed bench for lane_rr_scheduler with a scoreboard of expected grants.
module tb_lane_rr_scheduler;

  logic       clk4f = 1'b0;
  logic       reset_L;
  logic [8:0] data0, data1, data2, data3;
  logic [3:0] lane_en;
  logic       out_ready;
  logic [8:0] data_out;
  logic [1:0] grant;
  logic [3:0] lane_full;
  logic [3:0] err_overflow;

  int vectors     = 0;
  int miscompares = 0;

  // {grant, data_out} expected for each valid symbol, in emission order
  logic [10:0] sb [$];

  localparam logic [8:0] IDLE = 9'h0BC;

  lane_rr_scheduler dut (
    .clk4f        (clk4f),
    .reset_L      (reset_L),
    .data0        (data0),
    .data1        (data1),
    .data2        (data2),
    .data3        (data3),
    .lane_en      (lane_en),
    .out_ready    (out_ready),
    .data_out     (data_out),
    .grant        (grant),
    .lane_full    (lane_full),
    .err_overflow (err_overflow)
  );

  always #5 clk4f = ~clk4f;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk4f);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    vectors++;
    assert (obs === exp_v)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic expect_out(input string tag);
    logic [10:0] e;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s: scoreboard empty, observed %h expected none", tag, {grant, data_out});
    end else begin
      e = sb.pop_front();
      chk(tag, {5'b0, grant, data_out}, {5'b0, e});
    end
  endtask

  task automatic set_all(input logic [8:0] base);
    data0 = base;
    data1 = base + 9'd1;
    data2 = base + 9'd2;
    data3 = base + 9'd3;
  endtask

  initial begin
    reset_L = 1'b0; lane_en = 4'hF; out_ready = 1'b1;
    data0 = '0; data1 = '0; data2 = '0; data3 = '0;

    // reset held two cycles
    tick(); tick();
    chk("rst_data",  {7'b0, data_out}, {7'b0, IDLE});
    chk("rst_grant", {14'b0, grant}, 16'd0);
    chk("rst_full",  {12'b0, lane_full}, 16'd0);
    chk("rst_err",   {12'b0, err_overflow}, 16'd0);
    reset_L = 1'b1;

    // single lane: no same-edge bypass, one-cycle latency, then idle
    data0 = 9'h1C0; sb.push_back({2'd0, 9'h1C0});
    tick(); data0 = '0;
    chk("t2_no_bypass", {7'b0, data_out}, {7'b0, IDLE});
    tick(); expect_out("t2_out");
    tick(); chk("t2_idle", {7'b0, data_out}, {7'b0, IDLE});

    // round-robin from a fresh reset (search begins at lane 0)
    reset_L = 1'b0; tick(); reset_L = 1'b1;
    data0 = 9'h101; data1 = 9'h102; data2 = 9'h103; data3 = 9'h104;
    sb.push_back({2'd0, 9'h101}); sb.push_back({2'd1, 9'h102});
    sb.push_back({2'd2, 9'h103}); sb.push_back({2'd3, 9'h104});
    tick(); set_all(9'h000); data1 = '0; data2 = '0; data3 = '0;
    for (int i = 0; i < 4; i++) begin
      tick(); expect_out("t3_rr");
    end
    tick(); chk("t3_idle", {7'b0, data_out}, {7'b0, IDLE});

    // backpressure, fill and overflow on lane 2
    out_ready = 1'b0;
    data2 = 9'h111; tick();
    chk("t4_full_1", {12'b0, lane_full}, 16'h0000);
    data2 = 9'h122; tick();
    chk("t4_full_2", {12'b0, lane_full}, 16'h0004);
    chk("t4_err_2",  {12'b0, err_overflow}, 16'h0000);
    data2 = 9'h133; tick();
    chk("t4_err_3",  {12'b0, err_overflow}, 16'h0004);
    chk("t4_held",   {7'b0, data_out}, {7'b0, IDLE});
    data2 = '0; out_ready = 1'b1;
    sb.push_back({2'd2, 9'h111}); sb.push_back({2'd2, 9'h122});
    tick(); expect_out("t4_out1");
    chk("t4_unfull", {12'b0, lane_full}, 16'h0000);
    tick(); expect_out("t4_out2");
    out_ready = 1'b0;
    tick();
    chk("t4_hold_data",  {7'b0, data_out}, 16'h0122);
    chk("t4_hold_grant", {14'b0, grant}, 16'd2);
    out_ready = 1'b1;
    tick();
    chk("t4_idle",       {7'b0, data_out}, {7'b0, IDLE});
    chk("t4_idle_grant", {14'b0, grant}, 16'd2);

    // mask: only lanes 1 and 3 served, then 0 and 2 resume in order
    reset_L = 1'b0; tick(); reset_L = 1'b1;
    chk("t5_err_clr", {12'b0, err_overflow}, 16'h0000);
    out_ready = 1'b0;
    set_all(9'h120); tick();
    set_all(9'h130); tick();
    set_all(9'h000); data1 = '0; data2 = '0; data3 = '0;
    chk("t5_backlog", {12'b0, lane_full}, 16'h000F);
    lane_en = 4'b1010; out_ready = 1'b1;
    sb.push_back({2'd1, 9'h121}); sb.push_back({2'd3, 9'h123});
    sb.push_back({2'd1, 9'h131}); sb.push_back({2'd3, 9'h133});
    for (int i = 0; i < 4; i++) begin
      tick(); expect_out("t5_mask");
    end
    chk("t5_kept", {12'b0, lane_full}, 16'h0005);
    lane_en = 4'hF;
    sb.push_back({2'd0, 9'h120}); sb.push_back({2'd2, 9'h122});
    sb.push_back({2'd0, 9'h130}); sb.push_back({2'd2, 9'h132});
    for (int i = 0; i < 4; i++) begin
      tick(); expect_out("t5_resume");
    end
    tick(); chk("t5_idle", {7'b0, data_out}, {7'b0, IDLE});

    // reset mid-stream flushes everything
    out_ready = 1'b0;
    set_all(9'h140); tick();
    set_all(9'h150); tick();
    set_all(9'h000); data1 = 9'h1EE; data2 = '0; data3 = '0;
    tick(); data1 = '0;
    chk("t6_err_pre",  {12'b0, err_overflow}, 16'h0002);
    chk("t6_full_pre", {12'b0, lane_full}, 16'h000F);
    reset_L = 1'b0; out_ready = 1'b1;
    tick(); reset_L = 1'b1;
    chk("t6_rst_data", {7'b0, data_out}, {7'b0, IDLE});
    chk("t6_rst_err",  {12'b0, err_overflow}, 16'h0000);
    chk("t6_rst_full", {12'b0, lane_full}, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("t6_idle", {7'b0, data_out}, {7'b0, IDLE});
    end

    chk("sb_drained", 16'(sb.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
